// File: rtl/metacog_pkg.sv
// Shared constants, tick classification and helpers for the metacognitive
// exploit/explore channel array.
package metacog_pkg;

  localparam int unsigned DefNCh        = 4;
  localparam int unsigned DefStrW       = 4;
  localparam int unsigned DefConfW      = 2;
  localparam int unsigned DefExploitThr = 6;
  localparam int unsigned DefExploreThr = 5;
  localparam int unsigned DefConfExpThr = 2;
  localparam int unsigned DefDwell      = 2;
  localparam int unsigned DefQuorum     = 2;

  // Widest explore vector the popcount helper accepts.
  localparam int unsigned PopMaxW = 64;

  typedef enum logic [1:0] {
    TickHigh,
    TickLow,
    TickMid,
    TickLeak
  } tick_class_e;

  function automatic int unsigned conf_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic int unsigned popcount(input logic [PopMaxW-1:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PopMaxW; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/metacog_channel.sv
// One episodic channel: dwell and confidence counters, exploit flag with
// edge pulse, and the combinational explore flag.
module metacog_channel
  import metacog_pkg::*;
#(
  parameter int unsigned STR_W        = DefStrW,
  parameter int unsigned CONF_W       = DefConfW,
  parameter int unsigned EXPLOIT_THR  = DefExploitThr,
  parameter int unsigned EXPLORE_THR  = DefExploreThr,
  parameter int unsigned CONF_EXP_THR = DefConfExpThr,
  parameter int unsigned DWELL        = DefDwell
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              theta_tick,
  input  logic [STR_W-1:0]  ep_strength,
  input  logic              ep_valid,
  output logic              exploit_mode,
  output logic              explore_mode,
  output logic [CONF_W-1:0] confidence_level,
  output logic              mode_change
);

  localparam int unsigned       DwW      = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [DwW-1:0]    DwellL   = DwW'(DWELL);
  localparam logic [CONF_W-1:0] ConfMaxL = CONF_W'(conf_max(CONF_W));

  logic [DwW-1:0]    dwell_q, dwell_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic              exploit_q, exploit_d;
  logic              mode_change_q, mode_change_d;
  tick_class_e       tick_class;
  int unsigned       str_ext, conf_ext;

  assign str_ext  = 32'(ep_strength);
  assign conf_ext = 32'(conf_q);

  // High is tested first so it wins when the thresholds overlap.
  always_comb begin
    if (!ep_valid) begin
      tick_class = TickLeak;
    end else if (str_ext >= EXPLOIT_THR) begin
      tick_class = TickHigh;
    end else if (str_ext <= EXPLORE_THR) begin
      tick_class = TickLow;
    end else begin
      tick_class = TickMid;
    end
  end

  always_comb begin
    dwell_d   = dwell_q;
    conf_d    = conf_q;
    exploit_d = exploit_q;
    if (theta_tick) begin
      unique case (tick_class)
        TickHigh: begin
          dwell_d = (dwell_q >= DwellL) ? DwellL : dwell_q + DwW'(1);
          conf_d  = (conf_q == ConfMaxL) ? conf_q : conf_q + CONF_W'(1);
          if (dwell_d == DwellL) begin
            exploit_d = 1'b1;
            conf_d    = ConfMaxL;
          end
        end
        TickLow: begin
          conf_d    = (conf_q > CONF_W'(1)) ? conf_q - CONF_W'(1) : CONF_W'(1);
          dwell_d   = '0;
          exploit_d = 1'b0;
        end
        TickMid: begin
          dwell_d   = '0;
          exploit_d = 1'b0;
        end
        TickLeak: begin
          conf_d    = (conf_q != '0) ? conf_q - CONF_W'(1) : '0;
          dwell_d   = '0;
          exploit_d = 1'b0;
        end
        default: ;
      endcase
    end
    mode_change_d = exploit_d ^ exploit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q       <= '0;
      conf_q        <= '0;
      exploit_q     <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      conf_q        <= conf_d;
      exploit_q     <= exploit_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign exploit_mode     = exploit_q;
  assign confidence_level = conf_q;
  assign mode_change      = mode_change_q;
  assign explore_mode     = ep_valid && (str_ext <= EXPLORE_THR) && (conf_ext <= CONF_EXP_THR);

endmodule

// File: rtl/metacog_array.sv
// Array of independent metacognitive channels with a registered count of
// exploring channels and a quorum flag.
module metacog_array
  import metacog_pkg::*;
#(
  parameter int unsigned N_CH         = DefNCh,
  parameter int unsigned STR_W        = DefStrW,
  parameter int unsigned CONF_W       = DefConfW,
  parameter int unsigned EXPLOIT_THR  = DefExploitThr,
  parameter int unsigned EXPLORE_THR  = DefExploreThr,
  parameter int unsigned CONF_EXP_THR = DefConfExpThr,
  parameter int unsigned DWELL        = DefDwell,
  parameter int unsigned QUORUM       = DefQuorum
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     theta_tick,
  input  logic [N_CH*STR_W-1:0]    ep_strength,
  input  logic [N_CH-1:0]          ep_valid,
  output logic [N_CH-1:0]          exploit_mode,
  output logic [N_CH-1:0]          explore_mode,
  output logic [N_CH*CONF_W-1:0]   confidence_level,
  output logic [N_CH-1:0]          mode_change,
  output logic [$clog2(N_CH+1)-1:0] explore_count,
  output logic                     global_explore
);

  localparam int unsigned CntW = $clog2(N_CH + 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    metacog_channel #(
      .STR_W       (STR_W),
      .CONF_W      (CONF_W),
      .EXPLOIT_THR (EXPLOIT_THR),
      .EXPLORE_THR (EXPLORE_THR),
      .CONF_EXP_THR(CONF_EXP_THR),
      .DWELL       (DWELL)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .theta_tick      (theta_tick),
      .ep_strength     (ep_strength[i*STR_W +: STR_W]),
      .ep_valid        (ep_valid[i]),
      .exploit_mode    (exploit_mode[i]),
      .explore_mode    (explore_mode[i]),
      .confidence_level(confidence_level[i*CONF_W +: CONF_W]),
      .mode_change     (mode_change[i])
    );
  end

  int unsigned     pop;
  logic [CntW-1:0] count_q, count_d;
  logic            global_q, global_d;

  always_comb begin
    pop      = popcount(PopMaxW'(explore_mode));
    count_d  = CntW'(pop);
    global_d = (pop >= QUORUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      global_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      global_q <= global_d;
    end
  end

  assign explore_count  = count_q;
  assign global_explore = global_q;

endmodule
